// File: rtl/spi_master.sv
// spi_master: mode-0, MSB-first, 8-bit full-duplex SPI master with a valid/ready
// host byte interface. One frame per accepted byte:
// SETUP -> 16 sclk half-periods (SHIFT) -> HOLD -> GAP -> IDLE.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a 'loopback' input. When it
// is high, the internal mosi register is sampled instead of the miso pin.
module spi_master #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       sclk,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
`ifdef SPI_MASTER_LOOPBACK_EN
   ,
   input  logic       loopback
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   state_t           r_state;
   logic [DIV_W-1:0] r_div_cnt;
   logic [3:0]       r_edge_cnt;
   logic [7:0]       r_tx_shift;
   logic [7:0]       r_rx_shift;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_busy;
   logic             r_sclk;
   logic             r_ss_n;
   logic             r_mosi;

   logic             w_tick;
   logic             w_sample;

   assign w_tick = (r_div_cnt == DIV_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
   assign w_sample = loopback ? r_mosi : miso;
`else
   assign w_sample = miso;
`endif

   assign tx_ready = (r_state == S_IDLE);
   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign busy     = r_busy;
   assign sclk     = r_sclk;
   assign ss_n     = r_ss_n;
   assign mosi     = r_mosi;

   // Frame sequencer: divider, sclk/ss_n/mosi generation, and shift registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_div_cnt  <= '0;
         r_edge_cnt <= '0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_sclk     <= 1'b0;
         r_ss_n     <= 1'b1;
         r_mosi     <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_div_cnt <= '0;
               if (tx_valid) begin
                  r_tx_shift <= tx_data;
                  r_mosi     <= tx_data[7];
                  r_ss_n     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_tick) begin
                  r_div_cnt  <= '0;
                  r_edge_cnt <= '0;
                  r_state    <= S_SHIFT;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_SHIFT: begin
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_sclk    <= ~r_sclk;
                  if (!r_sclk) begin
                     // Rising sclk edge: capture the slave's bit.
                     r_rx_shift <= {r_rx_shift[6:0], w_sample};
                  end else if (r_edge_cnt != 4'd15) begin
                     // Falling sclk edge: present the next transmit bit.
                     r_mosi     <= r_tx_shift[6];
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end
                  if (r_edge_cnt == 4'd15) begin
                     r_edge_cnt <= '0;
                     r_state    <= S_HOLD;
                  end else begin
                     r_edge_cnt <= r_edge_cnt + 4'd1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (w_tick) begin
                  r_div_cnt  <= '0;
                  r_ss_n     <= 1'b1;
                  r_rx_data  <= r_rx_shift;
                  r_rx_valid <= 1'b1;
                  r_state    <= S_GAP;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            default: begin
               r_div_cnt <= '0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
